// File: rtl/control_pkg.sv
// Shared encodings for the multicycle main control FSM: opcodes, states,
// datapath select codes and the decoded control word.
package control_pkg;

  localparam logic [5:0] OP_R     = 6'd4;
  localparam logic [5:0] OP_ADDIU = 6'd12;
  localparam logic [5:0] OP_SUBIU = 6'd13;
  localparam logic [5:0] OP_SW    = 6'd16;
  localparam logic [5:0] OP_LW    = 6'd17;
  localparam logic [5:0] OP_BEQ   = 6'd19;
  localparam logic [5:0] OP_J     = 6'd28;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_EXEC_R   = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_ALU_WB   = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  localparam logic [1:0] ALU_SUB   = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       irWrite;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       instrDone;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags the cycle
// in which the wait budget would be exhausted.
module mem_wait_timer
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic ready,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // expired fires on the MEM_TIMEOUT-th not-ready cycle; ready in that cycle wins
  assign expired = waiting && !ready && (cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !waiting || ready || expired) cnt <= '0;
    else                                         cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style main control for the multicycle datapath: sequences fetch,
// decode, execute, memory and write-back, with memory stall and trap handling.
module multicycle_control
  import control_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Run,
  input  logic [OPCODE_W-1:0] OpCode,
  input  logic                Zero,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic                InstrDone,
  output logic                Trap,
  output logic [1:0]          TrapCause
);

  logic [3:0] state, nextState;
  logic [1:0] trapCause;
  logic       waiting, expired;
  logic       isR, isAddiu, isSubiu, isSw, isLw, isBeq, isJ;
  ctrl_t      ctl;

  // Zero only qualifies PCWriteCond inside the datapath
  logic unusedZero;
  assign unusedZero = Zero;

  assign isR     = (OpCode == OPCODE_W'(OP_R));
  assign isAddiu = (OpCode == OPCODE_W'(OP_ADDIU));
  assign isSubiu = (OpCode == OPCODE_W'(OP_SUBIU));
  assign isSw    = (OpCode == OPCODE_W'(OP_SW));
  assign isLw    = (OpCode == OPCODE_W'(OP_LW));
  assign isBeq   = (OpCode == OPCODE_W'(OP_BEQ));
  assign isJ     = (OpCode == OPCODE_W'(OP_J));

  assign waiting = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) uTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .waiting (waiting),
    .ready   (MemReady),
    .expired (expired)
  );

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:   if (Run) nextState = S_FETCH;
      S_FETCH:  if (MemReady) nextState = S_DECODE;
                else if (expired) nextState = S_TRAP;
      S_DECODE: begin
        if (isR)                   nextState = S_EXEC_R;
        else if (isAddiu || isSubiu) nextState = S_EXEC_I;
        else if (isLw || isSw)     nextState = S_MEM_ADDR;
        else if (isBeq)            nextState = S_BRANCH;
        else if (isJ)              nextState = S_JUMP;
        else                       nextState = S_TRAP;
      end
      S_EXEC_R, S_EXEC_I: nextState = S_ALU_WB;
      S_MEM_ADDR: nextState = isLw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (MemReady) nextState = S_MEM_WB;
                else if (expired) nextState = S_TRAP;
      S_MEM_WR: if (MemReady) nextState = Run ? S_FETCH : S_IDLE;
                else if (expired) nextState = S_TRAP;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: nextState = Run ? S_FETCH : S_IDLE;
      S_TRAP:   nextState = S_TRAP;
      default:  nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      trapCause <= TC_NONE;
    end else begin
      state <= nextState;
      // only DECODE can trap on an opcode; every other trap entry is a wait timeout
      if (state != S_TRAP && nextState == S_TRAP)
        trapCause <= (state == S_DECODE) ? TC_ILLEGAL : TC_TIMEOUT;
    end
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.memRead  = 1'b1;
        ctl.aluSrcB  = SRCB_FOUR;
        ctl.aluOp    = ALU_ADD;
        ctl.pcSource = PCS_ALU;
        ctl.irWrite  = MemReady;
        ctl.pcWrite  = MemReady;
      end
      S_DECODE: begin
        ctl.aluSrcB = SRCB_IMMSH;
        ctl.aluOp   = ALU_ADD;
      end
      S_EXEC_R: begin
        ctl.aluSrcA = 1'b1;
        ctl.aluSrcB = SRCB_REG;
        ctl.aluOp   = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ctl.aluSrcA = 1'b1;
        ctl.aluSrcB = SRCB_IMM;
        ctl.aluOp   = isSubiu ? ALU_SUB : ALU_ADD;
      end
      S_ALU_WB: begin
        ctl.regWrite  = 1'b1;
        ctl.regDst    = isR;
        ctl.instrDone = 1'b1;
      end
      S_MEM_ADDR: begin
        ctl.aluSrcA = 1'b1;
        ctl.aluSrcB = SRCB_IMM;
        ctl.aluOp   = ALU_ADD;
      end
      S_MEM_RD: begin
        ctl.memRead = 1'b1;
        ctl.iorD    = 1'b1;
      end
      S_MEM_WB: begin
        ctl.regWrite  = 1'b1;
        ctl.memtoReg  = 1'b1;
        ctl.instrDone = 1'b1;
      end
      S_MEM_WR: begin
        ctl.memWrite  = 1'b1;
        ctl.iorD      = 1'b1;
        ctl.instrDone = MemReady;
      end
      S_BRANCH: begin
        ctl.aluSrcA     = 1'b1;
        ctl.aluSrcB     = SRCB_REG;
        ctl.aluOp       = ALU_SUB;
        ctl.pcWriteCond = 1'b1;
        ctl.pcSource    = PCS_ALUOUT;
        ctl.instrDone   = 1'b1;
      end
      S_JUMP: begin
        ctl.pcWrite   = 1'b1;
        ctl.pcSource  = PCS_JUMP;
        ctl.instrDone = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

  assign PCWrite     = ctl.pcWrite;
  assign PCWriteCond = ctl.pcWriteCond;
  assign IorD        = ctl.iorD;
  assign IRWrite     = ctl.irWrite;
  assign MemRead     = ctl.memRead;
  assign MemWrite    = ctl.memWrite;
  assign MemtoReg    = ctl.memtoReg;
  assign RegDst      = ctl.regDst;
  assign RegWrite    = ctl.regWrite;
  assign ALUSrcA     = ctl.aluSrcA;
  assign ALUSrcB     = ctl.aluSrcB;
  assign ALUOp       = ALUOP_W'(ctl.aluOp);
  assign PCSource    = ctl.pcSource;
  assign InstrDone   = ctl.instrDone;
  assign Trap        = (state == S_TRAP);
  assign TrapCause   = trapCause;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: per-instruction expectations (length, done-cycle and
// preceding-cycle controls) are queued at issue and checked on each InstrDone.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n, Run, Zero, MemReady;
  logic [5:0] OpCode;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, InstrDone, Trap;
  logic [1:0] ALUSrcB, ALUOp, PCSource, TrapCause;

  typedef struct packed {
    logic PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
    logic MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic InstrDone, Trap;
    logic [1:0] TrapCause;
  } ov_t;

  typedef struct {
    logic [5:0] op;
    int         cycles;
    ov_t        doneV;
    ov_t        prevV;
  } exp_t;

  ov_t  outs;
  exp_t sbq[$];
  int   tests, failed;
  int   fetchLat, memLat;
  logic [5:0] legalOps [7] = '{6'd4, 6'd12, 6'd13, 6'd16, 6'd17, 6'd19, 6'd28};

  assign outs = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite,
                 MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                 InstrDone, Trap, TrapCause};

  multicycle_control #(.OPCODE_W(6), .ALUOP_W(2), .MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .Run(Run), .OpCode(OpCode), .Zero(Zero),
    .MemReady(MemReady), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .InstrDone(InstrDone), .Trap(Trap), .TrapCause(TrapCause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what each instruction must look like, from the ISA-level rules.
  // f/m = not-ready cycles before the fetch / data access completes.
  function automatic exp_t model(input logic [5:0] op, input int f, input int m);
    exp_t e;
    ov_t decodeV;
    decodeV = '0; decodeV.ALUSrcB = 2'b11; decodeV.ALUOp = 2'b01;
    e.op = op; e.doneV = '0; e.prevV = '0; e.cycles = 0;
    e.doneV.InstrDone = 1'b1;
    case (op)
      6'd4: begin
        e.cycles = 4 + f;
        e.doneV.RegWrite = 1'b1; e.doneV.RegDst = 1'b1;
        e.prevV.ALUSrcA = 1'b1; e.prevV.ALUSrcB = 2'b00; e.prevV.ALUOp = 2'b10;
      end
      6'd12, 6'd13: begin
        e.cycles = 4 + f;
        e.doneV.RegWrite = 1'b1;
        e.prevV.ALUSrcA = 1'b1; e.prevV.ALUSrcB = 2'b10;
        e.prevV.ALUOp = (op == 6'd12) ? 2'b01 : 2'b00;
      end
      6'd17: begin
        e.cycles = 5 + f + m;
        e.doneV.RegWrite = 1'b1; e.doneV.MemtoReg = 1'b1;
        e.prevV.MemRead = 1'b1; e.prevV.IorD = 1'b1;
      end
      6'd16: begin
        e.cycles = 4 + f + m;
        e.doneV.MemWrite = 1'b1; e.doneV.IorD = 1'b1;
        if (m > 0) begin
          e.prevV.MemWrite = 1'b1; e.prevV.IorD = 1'b1;
        end else begin
          e.prevV.ALUSrcA = 1'b1; e.prevV.ALUSrcB = 2'b10; e.prevV.ALUOp = 2'b01;
        end
      end
      6'd19: begin
        e.cycles = 3 + f;
        e.doneV.ALUSrcA = 1'b1; e.doneV.ALUOp = 2'b00;
        e.doneV.PCWriteCond = 1'b1; e.doneV.PCSource = 2'b01;
        e.prevV = decodeV;
      end
      default: begin
        e.cycles = 3 + f;
        e.doneV.PCWrite = 1'b1; e.doneV.PCSource = 2'b10;
        e.prevV = decodeV;
      end
    endcase
    return e;
  endfunction

  // Memory responder: holds MemReady low for the programmed latency of each access.
  initial begin
    int wc;
    wc = 0;
    MemReady = 1'b0;
    forever begin
      @(negedge clk);
      if (!(MemRead || MemWrite)) begin
        wc = 0; MemReady = 1'b0;
      end else if (wc >= (IorD ? memLat : fetchLat)) begin
        wc = 0; MemReady = 1'b1;
      end else begin
        wc++; MemReady = 1'b0;
      end
    end
  end

  // Monitor: an instruction starts at its first fetch request and ends at InstrDone.
  initial begin
    bit   inInstr;
    int   cyc;
    ov_t  prevOuts;
    exp_t e;
    inInstr = 0; cyc = 0; prevOuts = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        inInstr = 0;
      end else begin
        if (!inInstr && MemRead && !IorD) begin
          inInstr = 1; cyc = 0;
        end
        if (inInstr) cyc++;
        if (InstrDone) begin
          if (sbq.size() == 0) begin
            tests++; failed++;
            $display("FAIL unexpected_done: got InstrDone=1 expected no pending instruction");
          end else begin
            e = sbq.pop_front();
            check($sformatf("cycles_op%0d", e.op), cyc, e.cycles);
            check($sformatf("done_outs_op%0d", e.op), 32'(outs), 32'(e.doneV));
            check($sformatf("prev_outs_op%0d", e.op), 32'(prevOuts), 32'(e.prevV));
          end
          inInstr = 0;
        end
      end
      prevOuts = outs;
    end
  end

  task automatic doReset(input string name);
    Run = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check(name, 32'(outs), 32'd0);
    rst_n = 1'b1;
  endtask

  // Issue one instruction; DUT is at an instruction boundary on entry.
  task automatic issue(input logic [5:0] op, input int f, input int m, input bit runAfter);
    int n;
    OpCode = op; fetchLat = f; memLat = m; Run = 1'b1; Zero = 1'($urandom);
    sbq.push_back(model(op, f, m));
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!InstrDone && n < 200);
    check($sformatf("done_seen_op%0d", op), 32'(InstrDone), 32'd1);
    Run = runAfter;
    @(posedge clk); #1;
  endtask

  // Start from IDLE with Run=0, expect a trap after expCyc edges, then reset.
  task automatic trapRun(input string name, input logic [5:0] op, input int f, input int m,
                         input int expCyc, input logic [1:0] cause, input int hold);
    int  n;
    ov_t e;
    OpCode = op; fetchLat = f; memLat = m; Run = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!Trap && n < 100);
    check({name, "_cycles"}, n, expCyc);
    e = '0; e.Trap = 1'b1; e.TrapCause = cause;
    for (int i = 0; i < hold; i++) begin
      check({name, "_held"}, 32'(outs), 32'(e));
      @(posedge clk); #1;
    end
    doReset({name, "_reset"});
  endtask

  initial begin
    int n;
    tests = 0; failed = 0;
    rst_n = 1'b0; Run = 1'b0; Zero = 1'b0; OpCode = 6'd0;
    fetchLat = 0; memLat = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_outs", 32'(outs), 32'd0);
    end

    issue(6'd4,  0, 0, 1'b1);
    issue(6'd12, 0, 0, 1'b0);
    issue(6'd17, 0, 3, 1'b1);
    issue(6'd19, 0, 0, 1'b1);
    issue(6'd28, 0, 0, 1'b1);
    issue(6'd16, 0, 2, 1'b1);
    issue(6'd13, 1, 0, 1'b0);

    for (int i = 0; i < 60; i++)
      issue(legalOps[$urandom_range(0, 6)], $urandom_range(0, 5), $urandom_range(0, 5),
            (i == 59) ? 1'b0 : 1'($urandom));

    issue(6'd4,  15, 0,  1'b0);
    issue(6'd17, 0,  15, 1'b0);
    issue(6'd16, 2,  15, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);

    trapRun("illegal_trap",  6'd63, 0, 0,  3,  2'b01, 20);
    trapRun("fetch_timeout", 6'd4,  16, 0, 17, 2'b10, 3);
    trapRun("memrd_timeout", 6'd17, 0, 16, 20, 2'b10, 3);
    trapRun("memwr_timeout", 6'd16, 1, 16, 21, 2'b10, 3);

    OpCode = 6'd17; fetchLat = 0; memLat = 10; Run = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(MemRead && IorD) && n < 20);
    check("midrd_reached", 32'(MemRead && IorD), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    doReset("midrd_reset");
    @(posedge clk); #1;
    check("midrd_idle", 32'(outs), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Next-generation main control unit for the multicycle datapath.
- Replaces per-opcode combinational decode with a Moore FSM that sequences fetch, decode, execute, memory and write-back.
- Stalls on a memory ready handshake and traps on illegal opcodes or memory timeouts.
- Sits between the instruction register opcode field and all datapath mux, enable and ALU controls.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, ALUOp output width.
- MEM_TIMEOUT, 16, maximum consecutive wait cycles on MemReady before a trap; must be at least 1.
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk, in, 1, clock. All state changes on the rising edge.
- rst_n, in, 1, synchronous active-low reset.
- Run, in, 1, allows a new instruction to start at the instruction boundary.
- OpCode, in, OPCODE_W, opcode from the instruction register.
- Zero, in, 1, ALU zero flag.
- MemReady, in, 1, memory completes the current access this cycle.
- PCWrite, out, 1, unconditional PC load.
- PCWriteCond, out, 1, PC load qualified by Zero.
- IorD, out, 1, memory address source: 0 = PC, 1 = ALUOut.
- IRWrite, out, 1, instruction register load.
- MemRead, out, 1, memory read request.
- MemWrite, out, 1, memory write request.
- MemtoReg, out, 1, write-back data source: 1 = memory data register.
- RegDst, out, 1, destination register: 1 = Rd, 0 = Rt.
- RegWrite, out, 1, register file write.
- ALUSrcA, out, 1, ALU A input: 0 = PC, 1 = register A.
- ALUSrcB, out, 2, ALU B input: 00 = B, 01 = constant 4, 10 = immediate, 11 = shifted immediate.
- ALUOp, out, ALUOP_W, ALU operation: 00 = sub, 01 = add, 10 = R-type funct.
- PCSource, out, 2, PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- InstrDone, out, 1, one-cycle pulse in the last state of each instruction.
- Trap, out, 1, sticky error flag.
- TrapCause, out, 2, 01 = illegal opcode, 10 = memory timeout.

Behaviour:
- Decoded opcodes: R = 4, addiu = 12, subiu = 13, sw = 16, lw = 17, beq = 19, j = 28. Any other value is illegal.
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP.
- Reset: while rst_n = 0 at the clock edge, state goes to IDLE, the timeout counter clears, and Trap and TrapCause clear. IDLE drives every output to 0. A reset in any state, including mid-wait or TRAP, aborts in the same edge.
- Outputs are Moore-decoded from state. IRWrite and PCWrite in FETCH are additionally gated by MemReady. Any output not listed for a state is 0.
- IDLE: go to FETCH if Run = 1, otherwise stay.
- FETCH:
  - Outputs: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 01, PCSource = 00.
  - If MemReady: IRWrite = 1, PCWrite = 1, go to DECODE.
  - Otherwise stay and increment the counter.
- DECODE:
  - Outputs: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 01 (branch target precompute).
  - Next state: R to EXEC_R; addiu/subiu to EXEC_I; lw/sw to MEM_ADDR; beq to BRANCH; j to JUMP; illegal to TRAP with TrapCause = 01.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; go to ALU_WB.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 01 for addiu or 00 for subiu; go to ALU_WB.
- ALU_WB: RegWrite = 1, MemtoReg = 0, RegDst = 1 for R or 0 for I; InstrDone = 1; go to FETCH if Run = 1, else IDLE.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 01; go to MEM_RD for lw or MEM_WR for sw.
- MEM_RD: MemRead = 1, IorD = 1; wait for MemReady, then go to MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, RegDst = 0, InstrDone = 1; go to FETCH or IDLE as in ALU_WB.
- MEM_WR: MemWrite = 1, IorD = 1; wait for MemReady; assert InstrDone in the MemReady cycle; then go to FETCH or IDLE.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 00, PCWriteCond = 1, PCSource = 01, InstrDone = 1; go to FETCH or IDLE.
- JUMP: PCWrite = 1, PCSource = 10, InstrDone = 1; go to FETCH or IDLE.
- Timeout counter:
  - Counts consecutive not-ready cycles in FETCH, MEM_RD and MEM_WR.
  - Clears on MemReady and on any state change.
  - When the count reaches MEM_TIMEOUT with MemReady still 0, go to TRAP with TrapCause = 10.
  - MemReady in the same cycle the count reaches MEM_TIMEOUT wins: the access completes and no trap is taken.
- TRAP: all outputs 0 except Trap = 1; TrapCause held; only reset exits.
- Cycle counts with MemReady = 1 on the first request: R/addiu/subiu 4; lw 5; sw 4; beq 3; j 3.
- Opcode is sampled only in DECODE and in MEM_ADDR (lw vs sw), and in EXEC_I and ALU_WB (add vs sub, Rd vs Rt). The instruction register keeps it stable after FETCH.

Decomposition:
- control_pkg holds:
  - opcode constants;
  - state enumeration;
  - ALUOp, ALUSrcB and PCSource encodings;
  - TrapCause codes.
- Sub-module mem_wait_timer (parameters MEM_TIMEOUT, CNT_W; inputs waiting, ready; output expired).
- The FSM and output decode stay in multicycle_control.

Test Plan:
- Reset and IDLE: hold rst_n = 0 for 2 cycles, then Run = 0 → all outputs 0 and state stays IDLE; drop rst_n mid-MEM_RD → IDLE on the next edge with all outputs 0.
- Issue R (4) then addiu (12), with Run = 1 and MemReady = 1 → 4 cycles each. ALU_WB drives RegDst = 1 for R and 0 for addiu. One InstrDone pulse per instruction.
- lw (17) with MemReady low for 3 cycles in MEM_RD → MemRead and IorD held at 1 for 4 cycles, then MEM_WB with MemtoReg = 1 and RegWrite = 1; 8 cycles total.
- beq (19) and j (28) → 3 cycles each. BRANCH drives PCWriteCond = 1, PCSource = 01, ALUOp = 00. JUMP drives PCWrite = 1, PCSource = 10.
- Illegal opcode 63 → TRAP after DECODE with Trap = 1 and TrapCause = 01; state held for 20 cycles until reset.
- MemReady = 0 in FETCH with MEM_TIMEOUT = 16 → TRAP with TrapCause = 10. Repeat with MemReady = 1 exactly on the 16th wait cycle → no trap, enters DECODE.
